// File: rtl/demux_router_pkg.sv
// Shared types and constants for the demux_router block and its demux_slot holding registers.
package demux_router_pkg;

  typedef enum logic {
    PORT_EMPTY = 1'b0,
    PORT_FULL  = 1'b1
  } port_state_e;

  localparam logic [1:0] SEL_PORT1     = 2'b00;
  localparam logic [1:0] SEL_PORT1_ALT = 2'b01;
  localparam logic [1:0] SEL_PORT2     = 2'b10;
  localparam logic [1:0] SEL_PORT3     = 2'b11;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned CNT_W     = 16;

  // Both port-1 encodings collapse onto bit 0 of the one-hot.
  function automatic logic [NUM_PORTS-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_PORTS-1:0] oh;
    case (sel)
      SEL_PORT2: oh = 3'b010;
      SEL_PORT3: oh = 3'b100;
      default:   oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single router output port (EMPTY/FULL state, data, optional counter).
// Optional accepted-word counter enabled by DEMUX_ROUTER_STATS_EN.
module demux_slot
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [WIDTH-1:0]  data_i,
  output port_state_e       state_o,
  output logic              can_load_o,
  output logic [WIDTH-1:0]  data_o
`ifdef DEMUX_ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_o
`endif
);

  port_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a same-cycle accept and drain leaves the slot FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = PORT_FULL;
      data_d  = data_i;
    end else if (state_q == PORT_FULL && ready_i) begin
      state_d = PORT_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= PORT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign state_o    = state_q;
  assign data_o     = data_q;
  assign can_load_o = (state_q == PORT_EMPTY) || ready_i;

`ifdef DEMUX_ROUTER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_router.sv
// 1-to-3 demultiplexing router with a one-entry register per output port.
// Define DEMUX_ROUTER_STATS_EN to add per-port accepted-word counters cnt1..cnt3.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        select,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out1_valid,
  output logic [WIDTH-1:0]  out1_data,
  input  logic              out1_ready,
  output logic              out2_valid,
  output logic [WIDTH-1:0]  out2_data,
  input  logic              out2_ready,
  output logic              out3_valid,
  output logic [WIDTH-1:0]  out3_data,
  input  logic              out3_ready
`ifdef DEMUX_ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
`endif
);

  // Handshake: a word moves when valid && ready on a rising edge; on the input
  // side in_ready depends only on the selected port, on the output side the
  // consumer's ready drains the slot.

  logic [NUM_PORTS-1:0] sel_oh;
  logic [NUM_PORTS-1:0] slot_ready;
  logic [NUM_PORTS-1:0] slot_can_load;
  logic [NUM_PORTS-1:0] slot_load;
  logic                 accept;
  port_state_e          slot_state [NUM_PORTS];
  logic [WIDTH-1:0]     slot_data  [NUM_PORTS];
`ifdef DEMUX_ROUTER_STATS_EN
  logic [CNT_W-1:0]     slot_cnt   [NUM_PORTS];
`endif

  assign sel_oh     = sel_onehot(select);
  assign slot_ready = {out3_ready, out2_ready, out1_ready};
  assign in_ready   = reset_n && (|(sel_oh & slot_can_load));
  assign accept     = in_valid && in_ready;
  assign slot_load  = sel_oh & {NUM_PORTS{accept}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .load_i     (slot_load[p]),
      .ready_i    (slot_ready[p]),
      .data_i     (in_data),
      .state_o    (slot_state[p]),
      .can_load_o (slot_can_load[p]),
      .data_o     (slot_data[p])
`ifdef DEMUX_ROUTER_STATS_EN
      ,
      .cnt_o      (slot_cnt[p])
`endif
    );
  end

  assign out1_valid = (slot_state[0] == PORT_FULL);
  assign out2_valid = (slot_state[1] == PORT_FULL);
  assign out3_valid = (slot_state[2] == PORT_FULL);
  assign out1_data  = slot_data[0];
  assign out2_data  = slot_data[1];
  assign out3_data  = slot_data[2];

`ifdef DEMUX_ROUTER_STATS_EN
  assign cnt1 = slot_cnt[0];
  assign cnt2 = slot_cnt[1];
  assign cnt3 = slot_cnt[2];
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router (WIDTH = 8); counter checks run when DEMUX_ROUTER_STATS_EN is defined.
module tb_demux_router;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset_n;
  logic [1:0]       select;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out1_valid, out2_valid, out3_valid;
  logic [WIDTH-1:0] out1_data, out2_data, out3_data;
  logic             out1_ready, out2_ready, out3_ready;
`ifdef DEMUX_ROUTER_STATS_EN
  logic [15:0]      cnt1, cnt2, cnt3;
`endif

  int checks = 0;
  int errors = 0;

  demux_router #(
    .WIDTH(WIDTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .select     (select),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_data  (out2_data),
    .out2_ready (out2_ready),
    .out3_valid (out3_valid),
    .out3_data  (out3_data),
    .out3_ready (out3_ready)
`ifdef DEMUX_ROUTER_STATS_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt3       (cnt3)
`endif
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    select     = 2'b00;
    in_valid   = 1'b1;
    in_data    = 8'hEE;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    out3_ready = 1'b1;
    tick();
    tick();
    settle();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out1_valid", 32'(out1_valid), 32'd0);
    check("reset_out2_valid", 32'(out2_valid), 32'd0);
    check("reset_out3_valid", 32'(out3_valid), 32'd0);
    check("reset_out1_data", 32'(out1_data), 32'h0);

    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick();

    // Basic route to port 1
    select   = 2'b00;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    settle();
    check("basic_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("basic_out1_valid", 32'(out1_valid), 32'd1);
    check("basic_out1_data", 32'(out1_data), 32'hA5);
    check("basic_out2_valid", 32'(out2_valid), 32'd0);
    check("basic_out3_valid", 32'(out3_valid), 32'd0);
    tick();
    settle();
    check("drained_out1_valid", 32'(out1_valid), 32'd0);
    check("drained_out1_data_hold", 32'(out1_data), 32'hA5);

    // Stalled port 2
    out2_ready = 1'b0;
    select     = 2'b10;
    in_data    = 8'h11;
    in_valid   = 1'b1;
    tick();
    in_data = 8'h22;
    settle();
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    check("stall_out2_valid", 32'(out2_valid), 32'd1);
    check("stall_out2_data", 32'(out2_data), 32'h11);
    tick();
    settle();
    check("stall_out2_data_stable", 32'(out2_data), 32'h11);
    out2_ready = 1'b1;
    settle();
    check("stall_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("stall_second_valid", 32'(out2_valid), 32'd1);
    check("stall_second_data", 32'(out2_data), 32'h22);
    tick();
    settle();
    check("stall_port2_empty", 32'(out2_valid), 32'd0);

    // Port 1 blocked while port 3 flows; select switch re-evaluates in_ready
    out1_ready = 1'b0;
    select     = 2'b00;
    in_data    = 8'h77;
    in_valid   = 1'b1;
    tick();
    in_data = 8'h33;
    settle();
    check("blocked_sel00_in_ready", 32'(in_ready), 32'd0);
    select = 2'b01;
    settle();
    check("blocked_sel01_in_ready", 32'(in_ready), 32'd0);
    select = 2'b11;
    settle();
    check("switch_sel11_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("flow_out3_valid", 32'(out3_valid), 32'd1);
    check("flow_out3_data", 32'(out3_data), 32'h33);
    check("flow_out1_data", 32'(out1_data), 32'h77);
    check("flow_out1_valid", 32'(out1_valid), 32'd1);
    tick();
    settle();
    check("flow_out3_drained", 32'(out3_valid), 32'd0);

    // Same-cycle accept and drain on port 3
    out3_ready = 1'b0;
    select     = 2'b11;
    in_data    = 8'h44;
    in_valid   = 1'b1;
    tick();
    in_data    = 8'h55;
    out3_ready = 1'b1;
    settle();
    check("acc_drain_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid   = 1'b0;
    out3_ready = 1'b0;
    settle();
    check("acc_drain_out3_valid", 32'(out3_valid), 32'd1);
    check("acc_drain_out3_data", 32'(out3_data), 32'h55);

    // Reset mid-operation with all ports FULL
    out2_ready = 1'b0;
    select     = 2'b10;
    in_data    = 8'h66;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("full_all_valid", 32'({out3_valid, out2_valid, out1_valid}), 32'b111);
    check("full_out2_data", 32'(out2_data), 32'h66);
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    select     = 2'b00;
    out1_ready = 1'b1;
    settle();
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    tick();
    settle();
    check("midreset_valids", 32'({out3_valid, out2_valid, out1_valid}), 32'b000);
    check("midreset_datas", 32'({out3_data, out2_data, out1_data}), 32'h0);
    check("midreset_in_ready_after", 32'(in_ready), 32'd0);
    reset_n    = 1'b1;
    in_valid   = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    out3_ready = 1'b1;
    tick();

`ifdef DEMUX_ROUTER_STATS_EN
    check("cnt_reset", 32'({cnt3, cnt2, cnt1}), 32'h0);
    select   = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("cnt1_three", 32'(cnt1), 32'd3);
    check("cnt2_zero", 32'(cnt2), 32'd0);
    check("cnt3_zero", 32'(cnt3), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 65532; i++) begin
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("cnt1_max", 32'(cnt1), 32'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("cnt1_wrap", 32'(cnt1), 32'h0);
    check("cnt2_still_zero", 32'(cnt2), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of the input and of each output.
REQ-002 SHALL have ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- select  input  2  destination: 00/01 -> port 1, 10 -> port 2, 11 -> port 3.
- in_valid  input  1  input word offered.
- in_data  input  WIDTH  input word.
- in_ready  output  1  router accepts the word this cycle.
- outN_valid  output  1  port N (N = 1, 2, 3) holds a word.
- outN_data  output  WIDTH  port N word.
- outN_ready  input  1  port N consumer takes the word.

Function
REQ-003 SHALL hold, per port, a one-entry register with state EMPTY or FULL; outN_valid SHALL be 1 exactly when port N is FULL.
REQ-004 SHALL form in_ready combinationally from the selected port only: 1 if that port is EMPTY, or is FULL with outN_ready = 1 this cycle.
REQ-005 SHALL accept a word when in_valid and in_ready are both 1, loading in_data into the selected port on that edge; latency is 1 cycle (word visible on outN_data the next cycle).
REQ-006 SHALL complete a port transfer when outN_valid and outN_ready are both 1.
REQ-007 SHALL leave a FULL port FULL with the new word when accept and drain hit the same port in the same cycle.
REQ-008 SHALL move a FULL port to EMPTY on drain without a simultaneous accept to that port.
REQ-009 SHALL keep outN_data stable while outN_valid = 1 and outN_ready = 0.
REQ-010 SHALL keep unselected ports unaffected by in_valid and in_data; they still drain independently.
REQ-011 SHALL keep outN_data at its last loaded value after draining; it never goes X once reset is done.
REQ-012 SHALL treat select 00 and 01 identically.
REQ-013 SHALL let a change of select on a cycle with in_valid = 1 and in_ready = 0 take effect at once: no word is lost or duplicated, and in_ready re-evaluates against the new port.

Reset
REQ-014 SHALL, with reset_n = 0 at a rising edge, set every port to EMPTY, every outN_valid to 0 and every outN_data to 0.
REQ-015 SHALL hold in_ready at 0 while reset_n = 0.
REQ-016 SHALL discard words held in any port when reset is asserted mid-operation; no transfer completes on that edge.

Configuration
REQ-017 SHALL, with DEMUX_ROUTER_STATS_EN defined, add outputs cnt1, cnt2, cnt3 (16 bits each).
- Each counter increments on every accepted word routed to its port.
- Counters wrap 16'hFFFF -> 0.
- Counters reset to 0.
REQ-018 SHALL, without DEMUX_ROUTER_STATS_EN, omit these ports and counters entirely; the data path is otherwise identical.

Structure
REQ-019 SHALL place in a shared package:
- the port-state type (EMPTY, FULL);
- the select encodings;
- the port-count constant (3);
- the counter width constant (16).
REQ-020 SHALL implement one sub-module, demux_slot: a single-port holding register with state, load, drain and optional counter, instantiated three times.

Verification
REQ-021 SHALL cover, with WIDTH = 8 and all ready = 1:
- select = 00, in_data = 8'hA5, in_valid one cycle -> out1_valid = 1, out1_data = A5 the next cycle;
- out2/out3 stay valid = 0.
REQ-022 SHALL cover a stalled port:
- out2_ready = 0; send 8'h11 then 8'h22 with select = 10;
- in_ready drops after the first word, out2_data holds 11;
- raising out2_ready drains 11, and 22 appears the next cycle.
REQ-023 SHALL cover one port blocked while another flows:
- out1 FULL with out1_ready = 0; switch to select = 11 and send 8'h33;
- in_ready = 1, out3_data = 33, out1_data unchanged.
REQ-024 SHALL cover accept and drain on the same port in the same cycle:
- port 3 FULL with 8'h44; send 8'h55 to port 3 with out3_ready = 1;
- out3_valid stays 1 and out3_data = 55 the next cycle.
REQ-025 SHALL cover reset mid-operation:
- all three ports FULL; reset_n = 0 for one edge;
- all outN_valid = 0, all outN_data = 0, in_ready = 0 during reset.
REQ-026 SHALL cover the counters when DEMUX_ROUTER_STATS_EN is defined:
- 3 words to select 01 -> cnt1 = 3, cnt2 = 0, cnt3 = 0;
- cnt1 preloaded to 16'hFFFF by sending 65535 words to port 1, plus one more word -> cnt1 = 0.
